// File: rtl/neurosa_pkg.sv
// Shared constants for the spike event path: default field widths, spike word
// field offsets and the step FSM encodings used by spike_event_queue.
package neurosa_pkg;

    localparam int TEN_DATA_WIDTH  = 2;
    localparam int NEURON_ID_WIDTH = 9;

    // Spike word layout at default widths: {value[10:9], id[8:0]}
    localparam int VAL_MSB = 10;
    localparam int VAL_LSB = 9;
    localparam int ID_MSB  = 8;

    localparam logic [1:0] Q_IDLE    = 2'd0;
    localparam logic [1:0] Q_COLLECT = 2'd1;
    localparam logic [1:0] Q_DRAIN   = 2'd2;

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO: registered storage, wrapping pointers and an
// occupancy count. The head word is read combinationally from mem[rd_ptr].
module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count == (PTR_WIDTH+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Gate the head with empty so the outputs read zero after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_queue.sv
// Spike event queue: captures network spike words, filters zero spikes, buffers
// them in a FWFT FIFO and tracks step completion. Optional SPIKE_QUEUE_STATS_EN
// adds a per-value histogram of accepted pushes on output val_hist.
module spike_event_queue #(
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int FIFO_DEPTH      = 16,
    parameter int PTR_WIDTH       = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      top_en,
    input  logic                                      step_start,
    input  logic                                      step_end,
    input  logic                                      network_done,
    input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_word,
    input  logic                                      drop_zero,
    output logic                                      evt_valid,
    input  logic                                      evt_ready,
    output logic [NEURON_ID_WIDTH-1:0]                evt_id,
    output logic [TEN_DATA_WIDTH-1:0]                 evt_val,
    output logic [PTR_WIDTH:0]                        fifo_count,
    output logic                                      overflow,
    output logic [CNT_WIDTH-1:0]                      drop_cnt,
    output logic                                      step_done,
    output logic [1:0]                                dbg_state
`ifdef SPIKE_QUEUE_STATS_EN
    ,
    output logic [4*CNT_WIDTH-1:0]                    val_hist
`endif
);

    import neurosa_pkg::*;

    localparam int WORD_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Handshake: an event transfers on a clock edge where evt_valid and
    // evt_ready are both 1 and top_en is 1; evt_ready is ignored while
    // evt_valid is 0, and evt_valid/evt_id/evt_val hold until that transfer.

    logic [1:0]                state;
    logic [TEN_DATA_WIDTH-1:0] in_val;
    logic                      zero_spike;
    logic                      push_req;
    logic                      pop;
    logic                      push_ok;
    logic                      lost;
    logic                      step_go;
    logic                      drain_done;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [WORD_W-1:0]         head;

    assign dbg_state  = state;
    assign in_val     = spike_word[WORD_W-1 -: TEN_DATA_WIDTH];
    assign zero_spike = drop_zero && (in_val == '0);

    assign push_req   = top_en && (state == Q_COLLECT) && network_done && !zero_spike;
    assign pop        = top_en && evt_valid && evt_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign lost       = push_req && fifo_full && !pop;
    assign step_go    = top_en && (state == Q_IDLE) && step_start;
    assign drain_done = (state == Q_DRAIN) && (fifo_count == '0) && !push_ok;

    sync_fwft_fifo #(
        .DATA_WIDTH (WORD_W),
        .DEPTH      (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (spike_word),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_val   = head[WORD_W-1 -: TEN_DATA_WIDTH];
    assign evt_id    = head[NEURON_ID_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= Q_IDLE;
            step_done <= 1'b0;
        end else if (top_en) begin
            step_done <= 1'b0;
            case (state)
                Q_IDLE: begin
                    if (step_start) begin
                        state <= Q_COLLECT;
                    end
                end
                Q_COLLECT: begin
                    if (step_end) begin
                        state <= Q_DRAIN;
                    end
                end
                Q_DRAIN: begin
                    if (drain_done) begin
                        state     <= Q_IDLE;
                        step_done <= 1'b1;
                    end
                end
                default: state <= Q_IDLE;
            endcase
        end
    end

    // Loss bookkeeping covers only full-FIFO losses; zero-spike filtering is silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (step_go) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (lost) begin
            overflow <= 1'b1;
            if (drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef SPIKE_QUEUE_STATS_EN
    logic [CNT_WIDTH-1:0] hist [4];

    always_ff @(posedge clk) begin
        if (reset || step_go) begin
            for (int k = 0; k < 4; k++) begin
                hist[k] <= '0;
            end
        end else if (push_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (in_val == TEN_DATA_WIDTH'(k) && hist[k] != CNT_MAX) begin
                    hist[k] <= hist[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign val_hist = {hist[3], hist[2], hist[1], hist[0]};
`endif

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed bench for spike_event_queue: flow, zero filter, overflow, full
// push/pop, stall, reset mid-drain, pointer wrap and step_end coincidence.
module tb_spike_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        top_en;
    logic        step_start;
    logic        step_end;
    logic        network_done;
    logic [10:0] spike_word;
    logic        drop_zero;
    logic        evt_valid;
    logic        evt_ready;
    logic [8:0]  evt_id;
    logic [1:0]  evt_val;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        step_done;
    logic [1:0]  dbg_state;
`ifdef SPIKE_QUEUE_STATS_EN
    logic [63:0] val_hist;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    spike_event_queue dut (
        .clk          (clk),
        .reset        (reset),
        .top_en       (top_en),
        .step_start   (step_start),
        .step_end     (step_end),
        .network_done (network_done),
        .spike_word   (spike_word),
        .drop_zero    (drop_zero),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_val      (evt_val),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .step_done    (step_done),
        .dbg_state    (dbg_state)
`ifdef SPIKE_QUEUE_STATS_EN
        ,
        .val_hist     (val_hist)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] v, input logic [8:0] id);
        network_done = 1'b1;
        spike_word   = {v, id};
        tick();
        network_done = 1'b0;
    endtask

    task automatic pulse_start();
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
    endtask

    task automatic finish_step();
        step_end = 1'b1;
        tick();
        step_end = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; top_en = 1'b1; step_start = 1'b0; step_end = 1'b0;
        network_done = 1'b0; spike_word = '0; drop_zero = 1'b0; evt_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if (evt_valid !== 1'b0 || fifo_count !== 5'd0 || evt_id !== 9'd0 || evt_val !== 2'd0) begin
            n_err++;
            $display("FAIL reset_fifo: valid=%0b count=%0d id=%0d val=%0d, want 0 0 0 0", evt_valid, fifo_count, evt_id, evt_val);
        end
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0 || step_done !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_flags: ovf=%0b drop=%0d done=%0b state=%0d, want 0 0 0 0", overflow, drop_cnt, step_done, dbg_state);
        end
    endtask

    task automatic test_basic_flow();
        logic [10:0] words [3];
        words[0] = {2'b01, 9'd5};
        words[1] = {2'b10, 9'd300};
        words[2] = {2'b11, 9'd511};
        pulse_start();
        n_vec++;
        if (dbg_state !== 2'd1) begin
            n_err++;
            $display("FAIL flow_collect: state=%0d want 1", dbg_state);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(words[i][10:9], words[i][8:0]);
            n_vec++;
            if (evt_valid !== 1'b1 || {evt_val, evt_id} !== words[i]) begin
                n_err++;
                $display("FAIL flow_head%0d: valid=%0b word=%h want 1 %h", i, evt_valid, {evt_val, evt_id}, words[i]);
            end
        end
        tick();
        n_vec++;
        if (evt_valid !== 1'b0 || fifo_count !== 5'd0) begin
            n_err++;
            $display("FAIL flow_empty: valid=%0b count=%0d want 0 0", evt_valid, fifo_count);
        end
        step_end = 1'b1;
        tick();
        step_end = 1'b0;
        n_vec++;
        if (dbg_state !== 2'd2 || step_done !== 1'b0) begin
            n_err++;
            $display("FAIL flow_drain: state=%0d done=%0b want 2 0", dbg_state, step_done);
        end
        tick();
        n_vec++;
        if (dbg_state !== 2'd0 || step_done !== 1'b1) begin
            n_err++;
            $display("FAIL flow_done: state=%0d done=%0b want 0 1", dbg_state, step_done);
        end
        tick();
        n_vec++;
        if (step_done !== 1'b0) begin
            n_err++;
            $display("FAIL flow_done_pulse: done=%0b want 0", step_done);
        end
    endtask

    task automatic test_zero_filter();
        pulse_start();
        evt_ready = 1'b0;
        drop_zero = 1'b1;
        strobe(2'b00, 9'd7);
        strobe(2'b01, 9'd8);
        n_vec++;
        if (fifo_count !== 5'd1 || evt_id !== 9'd8 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL zero_drop: count=%0d id=%0d drop=%0d ovf=%0b want 1 8 0 0", fifo_count, evt_id, drop_cnt, overflow);
        end
        drop_zero = 1'b0;
        strobe(2'b00, 9'd7);
        strobe(2'b01, 9'd8);
        n_vec++;
        if (fifo_count !== 5'd3) begin
            n_err++;
            $display("FAIL zero_keep_count: count=%0d want 3", fifo_count);
        end
        evt_ready = 1'b1;
        tick();
        n_vec++;
        if (evt_id !== 9'd7 || evt_val !== 2'd0 || evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL zero_keep_head: id=%0d val=%0d valid=%0b want 7 0 1", evt_id, evt_val, evt_valid);
        end
        tick();
        n_vec++;
        if (evt_id !== 9'd8 || evt_val !== 2'd1) begin
            n_err++;
            $display("FAIL zero_keep_tail: id=%0d val=%0d want 8 1", evt_id, evt_val);
        end
        tick();
        finish_step();
        n_vec++;
        if (dbg_state !== 2'd0 || step_done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_step_done: state=%0d done=%0b want 0 1", dbg_state, step_done);
        end
    endtask

    task automatic test_overflow();
        logic [10:0] w;
        pulse_start();
        evt_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            w = {2'b10, 9'(100 + i)};
            if (i < 16) exp_q.push_back(w);
            strobe(w[10:9], w[8:0]);
        end
        n_vec++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL ovf_state: count=%0d ovf=%0b drop=%0d want 16 1 2", fifo_count, overflow, drop_cnt);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = exp_q.pop_front();
            n_vec++;
            if (evt_valid !== 1'b1 || {evt_val, evt_id} !== w) begin
                n_err++;
                $display("FAIL ovf_drain%0d: valid=%0b word=%h want 1 %h", i, evt_valid, {evt_val, evt_id}, w);
            end
            tick();
        end
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_empty: valid=%0b want 0", evt_valid);
        end
        finish_step();
        pulse_start();
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%0b drop=%0d want 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        logic [10:0] w;
        evt_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            w = {2'b01, 9'(200 + i)};
            exp_q.push_back(w);
            strobe(w[10:9], w[8:0]);
        end
        evt_ready = 1'b1;
        w = {2'b11, 9'd250};
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        strobe(w[10:9], w[8:0]);
        n_vec++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL full_pp_state: count=%0d ovf=%0b drop=%0d want 16 0 0", fifo_count, overflow, drop_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            w = exp_q.pop_front();
            n_vec++;
            if ({evt_val, evt_id} !== w) begin
                n_err++;
                $display("FAIL full_pp_drain%0d: word=%h want %h", i, {evt_val, evt_id}, w);
            end
            tick();
        end
    endtask

    task automatic test_stall_and_reset();
        evt_ready = 1'b0;
        strobe(2'b01, 9'd33);
        top_en = 1'b0;
        evt_ready = 1'b1;
        strobe(2'b10, 9'd44);
        n_vec++;
        if (fifo_count !== 5'd1 || evt_valid !== 1'b1 || evt_id !== 9'd33 || evt_val !== 2'd1) begin
            n_err++;
            $display("FAIL stall_hold: count=%0d valid=%0b id=%0d val=%0d want 1 1 33 1", fifo_count, evt_valid, evt_id, evt_val);
        end
        top_en = 1'b1;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(2'b01, 9'(34 + i));
        step_end = 1'b1;
        tick();
        step_end = 1'b0;
        n_vec++;
        if (dbg_state !== 2'd2 || fifo_count !== 5'd5) begin
            n_err++;
            $display("FAIL rst_pre: state=%0d count=%0d want 2 5", dbg_state, fifo_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b0 || dbg_state !== 2'd0 || step_done !== 1'b0 || fifo_count !== 5'd0 || evt_id !== 9'd0) begin
            n_err++;
            $display("FAIL rst_mid: valid=%0b state=%0d done=%0b count=%0d id=%0d want 0 0 0 0 0", evt_valid, dbg_state, step_done, fifo_count, evt_id);
        end
        tick();
        n_vec++;
        if (step_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done: done=%0b want 0", step_done);
        end
    endtask

    task automatic test_wrap_and_end();
        logic [10:0] w;
        pulse_start();
        evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = {2'(1 + (i % 3)), 9'((i * 13) % 512)};
            strobe(w[10:9], w[8:0]);
            n_vec++;
            if ({evt_val, evt_id} !== w || fifo_count !== 5'd1) begin
                n_err++;
                $display("FAIL wrap%0d: word=%h count=%0d want %h 1", i, {evt_val, evt_id}, fifo_count, w);
            end
        end
        w = {2'b10, 9'd77};
        step_end = 1'b1;
        strobe(w[10:9], w[8:0]);
        step_end = 1'b0;
        n_vec++;
        if (dbg_state !== 2'd2 || {evt_val, evt_id} !== w || fifo_count !== 5'd1) begin
            n_err++;
            $display("FAIL end_coincide: state=%0d word=%h count=%0d want 2 %h 1", dbg_state, {evt_val, evt_id}, fifo_count, w);
        end
        tick();
        n_vec++;
        if (evt_valid !== 1'b0 || step_done !== 1'b0) begin
            n_err++;
            $display("FAIL end_drained: valid=%0b done=%0b want 0 0", evt_valid, step_done);
        end
        tick();
        n_vec++;
        if (step_done !== 1'b1 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL end_done: done=%0b state=%0d want 1 0", step_done, dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_zero_filter();
        test_overflow();
        test_full_push_pop();
        test_stall_and_reset();
        test_wrap_and_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
